multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style control FSM sequencing a multi-cycle MIPS datapath: shared memory, IR, A/B/ALUOut/MDR registers, single ALU.
- Supports the same instruction subset as the single-cycle decoder: R-type, lw, sw, andi, ori, addiu, beq, j.
- ALUop encoding is unchanged, so the existing ALU control block is reused as-is.
- Adds a memory-ready handshake so instruction fetch and data access can stall on slow memory.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_ANDI, 6'b001100, and immediate
- OP_ORI, 6'b001101, or immediate
- OP_ADDIU, 6'b001001, add immediate unsigned
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  3  000=B, 001=4, 010=sext imm, 011=zext imm, 100=sext imm<<2
- ALUop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, for debug

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IMMEX=11, IMMWB=12, TRAP=13.
- Outputs are pure decode of the state register. Every output defaults to 0 unless listed for that state.
- Reset, asserted at any time (including mid-access):
  - state goes to INIT immediately.
  - All outputs are 0 while reset is high and in INIT; MemWrite drops asynchronously.
- INIT: next state FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALUop=000, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1. The PC advances exactly once per instruction.
- DECODE: ALUSrcA=0, ALUSrcB=100, ALUop=000 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R-type -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - andi, ori, addiu -> IMMEX
  - any other opcode -> FETCH, or TRAP with the optional feature
- MEMADR: ALUSrcA=1, ALUSrcB=010, ALUop=000. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=000, ALUop=010. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=000, ALUop=001, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- IMMEX: ALUSrcA=1.
  - addiu: ALUSrcB=010, ALUop=000.
  - andi: ALUSrcB=011, ALUop=011.
  - ori: ALUSrcB=011, ALUop=100.
  - Next IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- Latencies with mem_ready held at 1 (cycles FETCH..last state):
  - lw 5
  - sw 4
  - R-type / immediate 4
  - beq / j 3
  - Each stall cycle adds 1.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Opcode is sampled only in DECODE and MEMADR; it must stay stable from DECODE to instruction end.
- Unused encodings 14 and 15 go to FETCH on the next cycle with all outputs 0.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP holds all outputs 0 and stays there until reset, freezing the PC at the faulting instruction + 4.
  - An extra output port illegal_op (1 bit) is 1 only while in TRAP.
- Undefined:
  - An unknown opcode goes from DECODE to FETCH, so it executes as a no-op.
  - TRAP and illegal_op are absent; state 13 is treated as an unused encoding.

Test Plan:
- Reset high 2 cycles then release, mem_ready=1 -> state 0 then 1. All outputs 0 during reset; FETCH has IRWrite=1, PCWrite=1, ALUSrcB=001.
- lw (100011), mem_ready=1 -> states 1,2,3,4,5,1. MEMRD has IorD=1, MemRead=1; MEMWB has RegWrite=1, MemtoReg=1.
- FETCH with mem_ready=0 for 3 cycles then 1 -> 4 cycles in state 1. IRWrite/PCWrite=0 for the first 3 and 1 on the 4th; exactly one PC write.
- beq (000100) -> states 1,2,9,1. BRANCH has PCWriteCond=1, ALUop=001, PCSource=01, PCWrite=0. Then j (000010) -> 1,2,10,1 with PCSource=10, PCWrite=1.
- ori (001101) -> IMMEX has ALUSrcB=011, ALUop=100; IMMWB has RegWrite=1, RegDst=0. sw with mem_ready=0, reset asserted in MEMWR -> MemWrite=0 in the same cycle, state 0.
- Opcode 111111 -> without the macro: 1,2,1 with no writes. With MULTICYCLE_ILLEGAL_TRAP_EN: state 13, illegal_op=1 held for 10 cycles until reset.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore control FSM for a multi-cycle MIPS datapath (R-type, lw,
//            sw, andi, ori, addiu, beq, j) with a memory-ready handshake on
//            instruction fetch and data access.
// Options  : MULTICYCLE_ILLEGAL_TRAP_EN - unknown opcodes enter a TRAP state
//            (held until reset) and raise illegal_op; otherwise they retire
//            as no-ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [2:0] ALUSrcB,
   output logic [2:0] ALUop,
   output logic [1:0] PCSource,
   output logic [3:0] state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   ,
   output logic       illegal_op
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_IMMEX  = 4'd11,
      S_IMMWB  = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   // fetch_strobe marks FETCH; IR/PC loads are gated by mem_ready outside
   // the register so the PC advances only on the completing fetch cycle.
   typedef struct packed {
      logic       pc_write_uncond;
      logic       fetch_strobe;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   state_t r_state;
   state_t w_next_state;
   ctrl_t  r_ctrl;
   ctrl_t  w_next_ctrl;

   // Next-state selection; mem_ready only matters in the memory-wait states.
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_INIT:   w_next_state = S_FETCH;
         S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:               w_next_state = S_MEMADR;
               OP_RTYPE:                   w_next_state = S_EXEC;
               OP_BEQ:                     w_next_state = S_BRANCH;
               OP_J:                       w_next_state = S_JUMP;
               OP_ANDI, OP_ORI, OP_ADDIU:  w_next_state = S_IMMEX;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
               default:                    w_next_state = S_TRAP;
`else
               default:                    w_next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      w_next_state = S_MEMRD;
            else if (opcode == OP_SW) w_next_state = S_MEMWR;
            else                      w_next_state = S_FETCH;
         end
         S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next_state = S_FETCH;
         S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next_state = S_RWB;
         S_RWB:    w_next_state = S_FETCH;
         S_BRANCH: w_next_state = S_FETCH;
         S_JUMP:   w_next_state = S_FETCH;
         S_IMMEX:  w_next_state = S_IMMWB;
         S_IMMWB:  w_next_state = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
         S_TRAP:   w_next_state = S_TRAP;
`endif
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Control decode of the state being entered, so the registered outputs
   // always equal the decode of the current state register.
   always_comb begin
      w_next_ctrl = '0;
      case (w_next_state)
         S_FETCH: begin
            w_next_ctrl.fetch_strobe = 1'b1;
            w_next_ctrl.mem_read     = 1'b1;
            w_next_ctrl.alu_src_b    = 3'b001;
         end
         S_DECODE: w_next_ctrl.alu_src_b = 3'b100;
         S_MEMADR: begin
            w_next_ctrl.alu_src_a = 1'b1;
            w_next_ctrl.alu_src_b = 3'b010;
         end
         S_MEMRD: begin
            w_next_ctrl.mem_read = 1'b1;
            w_next_ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            w_next_ctrl.reg_write  = 1'b1;
            w_next_ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            w_next_ctrl.mem_write = 1'b1;
            w_next_ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            w_next_ctrl.alu_src_a = 1'b1;
            w_next_ctrl.alu_op    = 3'b010;
         end
         S_RWB: begin
            w_next_ctrl.reg_write = 1'b1;
            w_next_ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            w_next_ctrl.alu_src_a     = 1'b1;
            w_next_ctrl.alu_op        = 3'b001;
            w_next_ctrl.pc_write_cond = 1'b1;
            w_next_ctrl.pc_source     = 2'b01;
         end
         S_JUMP: begin
            w_next_ctrl.pc_write_uncond = 1'b1;
            w_next_ctrl.pc_source       = 2'b10;
         end
         S_IMMEX: begin
            // Opcode is stable from DECODE, so it selects the immediate flavour.
            w_next_ctrl.alu_src_a = 1'b1;
            if (opcode == OP_ANDI) begin
               w_next_ctrl.alu_src_b = 3'b011;
               w_next_ctrl.alu_op    = 3'b011;
            end else if (opcode == OP_ORI) begin
               w_next_ctrl.alu_src_b = 3'b011;
               w_next_ctrl.alu_op    = 3'b100;
            end else begin
               w_next_ctrl.alu_src_b = 3'b010;
            end
         end
         S_IMMWB: w_next_ctrl.reg_write = 1'b1;
         default: w_next_ctrl = '0;
      endcase
   end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   logic r_illegal;
`endif

   // State and registered control outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_INIT;
         r_ctrl    <= '0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         r_state   <= w_next_state;
         r_ctrl    <= w_next_ctrl;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
         r_illegal <= (w_next_state == S_TRAP);
`endif
      end
   end

   assign PCWrite     = r_ctrl.pc_write_uncond | (r_ctrl.fetch_strobe & mem_ready);
   assign IRWrite     = r_ctrl.fetch_strobe & mem_ready;
   assign PCWriteCond = r_ctrl.pc_write_cond;
   assign IorD        = r_ctrl.iord;
   assign MemRead     = r_ctrl.mem_read;
   assign MemWrite    = r_ctrl.mem_write;
   assign MemtoReg    = r_ctrl.mem_to_reg;
   assign RegDst      = r_ctrl.reg_dst;
   assign RegWrite    = r_ctrl.reg_write;
   assign ALUSrcA     = r_ctrl.alu_src_a;
   assign ALUSrcB     = r_ctrl.alu_src_b;
   assign ALUop       = r_ctrl.alu_op;
   assign PCSource    = r_ctrl.pc_source;
   assign state       = r_state;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   assign illegal_op  = r_illegal;
`endif

endmodule

`default_nettype wire
